// File: rtl/waterfall_scheduler_pkg.sv
// Shared types and width helpers for the waterfall scheduler slice.
package waterfall_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_SDFT = 3'd2,
    S_COPY      = 3'd3,
    S_DRAIN     = 3'd4
  } state_t;

  // Widths never collapse to zero, so single-entry configurations still elaborate.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int bin_w(input int freq_bins);
    return width_of(freq_bins);
  endfunction

  function automatic int row_w(input int v_visible);
    return width_of(v_visible);
  endfunction

  function automatic int addr_w(input int v_visible, input int limit_bins);
    return width_of(v_visible * limit_bins);
  endfunction

endpackage

// File: rtl/waterfall_scheduler_if.sv
// Bundle of the ADC, sdft, BRAM and display-timing signals around the scheduler.
interface waterfall_scheduler_if
  import waterfall_scheduler_pkg::*;
#(
  parameter int FREQ_BINS  = 64,
  parameter int LIMIT_BINS = 32,
  parameter int V_VISIBLE  = 10,
  parameter int MAG_W      = 16,
  parameter int DATA_W     = 8
) ();

  localparam int BIN_W  = bin_w(FREQ_BINS);
  localparam int ROW_W  = row_w(V_VISIBLE);
  localparam int ADDR_W = addr_w(V_VISIBLE, LIMIT_BINS);

  logic              sample_valid;
  logic              sdft_start;
  logic              sdft_ready;
  logic [BIN_W-1:0]  bin_addr;
  logic [MAG_W-1:0]  bin_mag;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_waddr;
  logic [DATA_W-1:0] bram_wdata;
  logic              vsync;
  logic [ROW_W-1:0]  scroll_row;
  logic              busy;
  logic              overrun;

  modport master (
    input  sample_valid, sdft_ready, bin_mag, vsync,
    output sdft_start, bin_addr, bram_we, bram_waddr, bram_wdata,
           scroll_row, busy, overrun
  );

  modport slave (
    output sample_valid, sdft_ready, bin_mag, vsync,
    input  sdft_start, bin_addr, bram_we, bram_waddr, bram_wdata,
           scroll_row, busy, overrun
  );

endinterface

// File: rtl/waterfall_scheduler_mag_saturate.sv
// Combinational clamp of an sdft magnitude onto the BRAM pixel width.
module waterfall_scheduler_mag_saturate
  import waterfall_scheduler_pkg::*;
#(
  parameter int MAG_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic [MAG_W-1:0]  i_mag,
  output logic [DATA_W-1:0] o_data
);

  generate
    if (MAG_W > DATA_W) begin : g_clamp
      assign o_data = (|i_mag[MAG_W-1:DATA_W]) ? '1 : i_mag[DATA_W-1:0];
    end else begin : g_pass
      assign o_data = DATA_W'(i_mag);
    end
  endgenerate

endmodule

// File: rtl/waterfall_scheduler.sv
// Sequences sdft updates per ADC sample and copies every DECIMATE-th spectrum
// into the circular waterfall BRAM, publishing the newest row at vsync.
module waterfall_scheduler
  import waterfall_scheduler_pkg::*;
#(
  parameter int FREQ_BINS  = 64,
  parameter int LIMIT_BINS = 32,
  parameter int V_VISIBLE  = 10,
  parameter int MAG_W      = 16,
  parameter int DATA_W     = 8,
  parameter int DECIMATE   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  waterfall_scheduler_if.master bus
);

  localparam int BIN_W   = bin_w(FREQ_BINS);
  localparam int ROW_W   = row_w(V_VISIBLE);
  localparam int ADDR_W  = addr_w(V_VISIBLE, LIMIT_BINS);
  localparam int DECIM_W = width_of(DECIMATE);

  localparam logic [BIN_W-1:0]   K_LAST     = BIN_W'(LIMIT_BINS - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(V_VISIBLE - 1);
  localparam logic [DECIM_W-1:0] DECIM_LAST = DECIM_W'(DECIMATE - 1);

  state_t             r_state;
  logic [DECIM_W-1:0] r_decim;
  logic [ROW_W-1:0]   r_row;
  logic [ROW_W-1:0]   r_last_row;
  logic [ROW_W-1:0]   r_scroll_row;
  logic               r_vsync_d;
  logic               r_sdft_start;
  logic [BIN_W-1:0]   r_bin_addr;
  logic               r_we;
  logic [ADDR_W-1:0]  r_waddr;
  logic               r_busy;
  logic               r_overrun;

  logic [ADDR_W-1:0]  w_row_base;
  logic [DATA_W-1:0]  w_sat;

  assign w_row_base = ADDR_W'(int'(r_row) * LIMIT_BINS);

  waterfall_scheduler_mag_saturate #(
    .MAG_W  (MAG_W),
    .DATA_W (DATA_W)
  ) u_mag_saturate (
    .i_mag  (bus.bin_mag),
    .o_data (w_sat)
  );

  // r_bin_addr doubles as the copy counter k while in COPY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_decim      <= '0;
      r_row        <= '0;
      r_last_row   <= '0;
      r_scroll_row <= '0;
      r_vsync_d    <= 1'b0;
      r_sdft_start <= 1'b0;
      r_bin_addr   <= '0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_vsync_d    <= bus.vsync;
      r_sdft_start <= 1'b0;
      // Latching the pre-update last_row keeps a DRAIN-coincident frame tear-free.
      if (bus.vsync && !r_vsync_d) begin
        r_scroll_row <= r_last_row;
      end
      if (bus.sample_valid && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.sample_valid) begin
            r_state      <= S_START;
            r_sdft_start <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_START: begin
          r_state <= S_WAIT_SDFT;
        end
        S_WAIT_SDFT: begin
          if (bus.sdft_ready) begin
            if (r_decim == DECIM_LAST) begin
              r_decim    <= '0;
              r_bin_addr <= '0;
              r_state    <= S_COPY;
            end else begin
              r_decim <= r_decim + DECIM_W'(1);
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_COPY: begin
          // Magnitude for bin k arrives one cycle later, so the write trails by one.
          r_we    <= 1'b1;
          r_waddr <= w_row_base + ADDR_W'(r_bin_addr);
          if (r_bin_addr == K_LAST) begin
            r_bin_addr <= '0;
            r_state    <= S_DRAIN;
          end else begin
            r_bin_addr <= r_bin_addr + BIN_W'(1);
          end
        end
        S_DRAIN: begin
          r_we       <= 1'b0;
          r_waddr    <= '0;
          r_last_row <= r_row;
          r_row      <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sdft_start = r_sdft_start;
  assign bus.bin_addr   = r_bin_addr;
  assign bus.bram_we    = r_we;
  assign bus.bram_waddr = r_waddr;
  assign bus.bram_wdata = r_we ? w_sat : '0;
  assign bus.scroll_row = r_scroll_row;
  assign bus.busy       = r_busy;
  assign bus.overrun    = r_overrun;

endmodule

// File: doc/waterfall_scheduler.md
Name: waterfall_scheduler

Overview:
- Sequences the sliding-DFT datapath: every accepted ADC sample triggers one sdft update.
- Every DECIMATE-th completed spectrum is copied into the waterfall frequency BRAM, one row per spectrum.
- Maintains the circular row pointer and hands the display a tear-free scroll row, latched only at vsync.
- Sits between the ADC front end, sdft, freq_bram and the VGA/LED display timing in top.

Parameters:
- FREQ_BINS, 64, bins computed by sdft; sets bin_addr width = clog2(FREQ_BINS).
- LIMIT_BINS, 32, low bins copied per row; must be <= FREQ_BINS.
- V_VISIBLE, 10, rows in the waterfall BRAM.
- MAG_W, 16, width of the sdft magnitude read port.
- DATA_W, 8, width of BRAM pixel data.
- DECIMATE, 4, commit one spectrum every DECIMATE sdft updates; must be >= 1.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- sample_valid, input, 1, one-cycle pulse from the ADC block when a new sample is available.
- sdft_start, output, 1, one-cycle pulse telling sdft to consume the sample.
- sdft_ready, input, 1, sdft update complete; level or pulse, sampled only in WAIT_SDFT.
- bin_addr, output, clog2(FREQ_BINS), sdft magnitude read address.
- bin_mag, input, MAG_W, magnitude for bin_addr, valid one cycle after the address.
- bram_we, output, 1, BRAM write enable.
- bram_waddr, output, clog2(V_VISIBLE*LIMIT_BINS), equal to row*LIMIT_BINS + bin.
- bram_wdata, output, DATA_W, saturated magnitude.
- vsync, input, 1, display frame sync, active-high.
- scroll_row, output, clog2(V_VISIBLE), newest complete row; display starts drawing here.
- busy, output, 1, high in any state except IDLE.
- overrun, output, 1, sticky; set when a sample is dropped; cleared only by reset.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - All outputs go to 0: sdft_start, bin_addr, bram_we, bram_waddr, bram_wdata, scroll_row, busy, overrun.
  - Internal row pointer, decimation counter, copy counter and last_row all reset to 0.
  - A reset mid-COPY abandons the partial row; the next committed row is row 0.
- State machine:
  - IDLE: when sample_valid=1, go to START.
  - START: sdft_start=1 for exactly this one cycle, then go to WAIT_SDFT.
  - WAIT_SDFT: on sdft_ready=1:
    - if decim == DECIMATE-1: set decim to 0 and go to COPY;
    - otherwise: increment decim and go to IDLE.
  - COPY: lasts LIMIT_BINS cycles, k = 0..LIMIT_BINS-1.
    - Cycle k drives bin_addr=k.
    - In cycles k>=1, bram_we=1, bram_waddr = row*LIMIT_BINS + (k-1), bram_wdata = sat(bin_mag).
    - After k=LIMIT_BINS-1, go to DRAIN.
  - DRAIN: one cycle; writes bin LIMIT_BINS-1.
    - last_row <= row.
    - row <= (row == V_VISIBLE-1) ? 0 : row+1.
    - Go to IDLE.
- Latency:
  - sample_valid to sdft_start: 1 cycle.
  - sdft_ready to first write: 2 cycles.
  - Each committed row takes exactly LIMIT_BINS write cycles, with consecutive addresses.
- Saturation: if bin_mag[MAG_W-1:DATA_W] != 0, bram_wdata = all ones; otherwise bram_wdata = bin_mag[DATA_W-1:0].
- Overrun: sample_valid is accepted only in IDLE.
  - A pulse in any other state, including the DRAIN cycle, is dropped and sets overrun.
  - A dropped sample does not advance decim.
- scroll_row: on a rising edge of vsync (registered previous value), scroll_row <= last_row.
  - Held constant for the whole frame.
  - If DRAIN and the vsync edge occur in the same cycle, the pre-DRAIN last_row is latched; the new row appears at the next frame.
- bram_we is never asserted outside COPY (k>=1) and DRAIN.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, START, WAIT_SDFT, COPY, DRAIN);
  - the clog2 width helpers for bin, row and BRAM address widths.
- One natural sub-module: mag_saturate (combinational MAG_W to DATA_W clamp). Everything else stays flat.

Test Plan:
- Single sample, DECIMATE=1, bin_mag=bin index:
  - sdft_start pulses 1 cycle after sample_valid.
  - After sdft_ready, 32 writes to addresses 0..31 with data 0..31.
  - Row advances to 1; busy drops.
- Saturation: bin_mag=0x0100 -> wdata=0xFF; bin_mag=0x00FE -> 0xFE.
- DECIMATE=4, 8 samples spaced 100 cycles apart:
  - exactly 2 row commits, at the 4th and 8th sdft_ready;
  - writes land in rows 0 and 1 (addresses 0..31, then 32..63).
- Wrap, DECIMATE=1:
  - 11 committed spectra with V_VISIBLE=10;
  - the 10th writes addresses 288..319, the 11th writes 0..31;
  - after vsync, scroll_row=0.
- Overrun: sample_valid during COPY -> overrun=1 and stays set; that sample produces no sdft_start; the following IDLE sample is processed normally.
- Reset asserted mid-COPY at k=10:
  - bram_we falls immediately, all outputs are 0;
  - the next commit writes row 0 from address 0.
